// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - PC, instruction-memory and decode signals of the fetch sequencer
interface fetch_sequencer_if;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        halted;
    logic [1:0]  fault_code;

    modport master (
        input  pc_q,
        output pc_d,
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc,
        input  redirect_valid,
        input  redirect_target,
        input  halt_req,
        output halted,
        output fault_code
    );

    modport slave (
        output pc_q,
        input  pc_d,
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc,
        output redirect_valid,
        output redirect_target,
        output halt_req,
        input  halted,
        input  fault_code
    );
endinterface

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch/issue sequencer driving the program counter d input
module fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          ACK_TIMEOUT  = 16
) (
    input  logic               clk,
    input  logic               clr,
    fetch_sequencer_if.master  bus
);
    localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    localparam logic [2:0] ST_BOOT  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_HALT  = 3'd3;
    localparam logic [2:0] ST_FAULT = 3'd4;

    localparam logic [1:0] FAULT_NONE     = 2'b00;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'b01;
    localparam logic [1:0] FAULT_MISALIGN = 2'b10;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_instr;
    logic [31:0]      r_instr_pc;
    logic [1:0]       r_fault;

    logic [2:0]       w_state_nxt;
    logic [31:0]      w_pc_d;
    logic             w_fetching;
    logic             w_fetch_done;
    logic             w_timeout;
    logic             w_handshake;
    logic             w_redir_bad;

    assign w_fetching   = (r_state == ST_FETCH);
    assign w_fetch_done = w_fetching && bus.imem_ack;
    assign w_timeout    = w_fetching && !bus.imem_ack && (r_count == CNT_LAST);
    assign w_handshake  = (r_state == ST_ISSUE) && bus.instr_ready;
    assign w_redir_bad  = bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);

    // The PC register loads every cycle, so pc_d must echo pc_q whenever it should hold.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_d      = bus.pc_q;
        case (r_state)
            ST_BOOT: begin
                w_pc_d      = RESET_VECTOR;
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    w_state_nxt = ST_ISSUE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_FAULT;
                end
            end
            ST_ISSUE: begin
                if (w_handshake) begin
                    if (w_redir_bad) begin
                        w_state_nxt = ST_FAULT;
                    end else begin
                        if (bus.redirect_valid) begin
                            w_pc_d = bus.redirect_target;
                        end else begin
                            w_pc_d = bus.pc_q + 32'd4;
                        end
                        w_state_nxt = bus.halt_req ? ST_HALT : ST_FETCH;
                    end
                end
            end
            ST_HALT:  w_state_nxt = ST_HALT;
            ST_FAULT: w_state_nxt = ST_FAULT;
            default:  w_state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= ST_BOOT;
            r_count    <= '0;
            r_instr    <= 32'h0;
            r_instr_pc <= 32'h0;
            r_fault    <= FAULT_NONE;
        end else begin
            r_state <= w_state_nxt;
            // Any cycle outside a waiting fetch zeroes the count, so each FETCH entry starts at 0.
            if (w_fetching && !bus.imem_ack) begin
                r_count <= r_count + CNT_W'(1);
            end else begin
                r_count <= '0;
            end
            if (w_fetch_done) begin
                r_instr    <= bus.imem_rdata;
                r_instr_pc <= bus.pc_q;
            end
            if (w_timeout) begin
                r_fault <= FAULT_TIMEOUT;
            end else if (w_handshake && w_redir_bad) begin
                r_fault <= FAULT_MISALIGN;
            end
        end
    end

    assign bus.pc_d        = w_pc_d;
    assign bus.imem_req    = w_fetching;
    assign bus.imem_addr   = bus.pc_q;
    assign bus.instr_valid = (r_state == ST_ISSUE);
    assign bus.instr       = r_instr;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.halted      = (r_state == ST_HALT) || (r_state == ST_FAULT);
    assign bus.fault_code  = r_fault;
endmodule
